enc_stream_collector: RTL

- Receive-side companion to the turbo encoder control path.
- Consumes the encoder's output stream: systematic d0 plus parity d1/d2, one triplet per out_valid cycle.
- Separates K data triplets from the 4 trellis-termination triplets, writes data triplets to an external 3-bit-wide block RAM, and captures the 12 tail bits in a register.
- Hands each completed block to the downstream consumer with a ready/ack handshake.

---
 rtl/enc_stream_collector.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/enc_stream_collector.sv
// Collects the turbo encoder output stream: data triplets go to RAM, tail triplets to a register.
// Optional macro SYS_CRC24B_EN adds a gCRC24B check over the systematic data bits.
module enc_stream_collector #(
    parameter int K_SMALL = 1056,
    parameter int K_LARGE = 6144,
    parameter int AW      = 13
) (
    input  logic          clock,
    input  logic          aclr_n,
    input  logic          in_valid,
    input  logic          d0,
    input  logic          d1,
    input  logic          d2,
    input  logic          blk_size,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [2:0]    wr_data,
    output logic [11:0]   tail_bits,
    output logic          blk_len_sel,
    output logic          blk_ready,
    input  logic          blk_ack,
    output logic          busy,
    output logic          err_overflow,
    output logic          crc_ok
);

    // state | meaning
    // IDLE  | waiting for the first beat of a block
    // DATA  | data beats 1..K-1 written to RAM
    // TAIL  | four termination beats captured into tail_bits
    // HOLD  | block complete, blk_ready high until blk_ack
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DATA = 2'd1;
    localparam logic [1:0] S_TAIL = 2'd2;
    localparam logic [1:0] S_HOLD = 2'd3;

    localparam logic [AW-1:0] LAST_SMALL = AW'(K_SMALL - 1);
    localparam logic [AW-1:0] LAST_LARGE = AW'(K_LARGE - 1);

    logic [1:0]    state;
    logic [AW-1:0] dcnt;
    logic [1:0]    tcnt;
    logic [AW-1:0] last_cur;
    logic [AW-1:0] last_new;
    logic [3:0]    tslot;
    logic [2:0]    triplet;

    assign triplet  = {d2, d1, d0};
    assign last_cur = blk_len_sel ? LAST_LARGE : LAST_SMALL;
    assign last_new = blk_size ? LAST_LARGE : LAST_SMALL;
    assign tslot    = {tcnt, 1'b0} + {2'b00, tcnt};
    assign busy      = (state != S_IDLE);
    assign blk_ready = (state == S_HOLD);

    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            state        <= S_IDLE;
            dcnt         <= '0;
            tcnt         <= '0;
            wr_en        <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
            tail_bits    <= '0;
            blk_len_sel  <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        blk_len_sel <= blk_size;
                        wr_en       <= 1'b1;
                        wr_addr     <= '0;
                        wr_data     <= triplet;
                        dcnt        <= AW'(1);
                        tcnt        <= '0;
                        state       <= (last_new == '0) ? S_TAIL : S_DATA;
                    end
                end
                S_DATA: begin
                    if (in_valid) begin
                        wr_en   <= 1'b1;
                        wr_addr <= dcnt;
                        wr_data <= triplet;
                        dcnt    <= dcnt + AW'(1);
                        // terminal count at K-1 keeps dcnt from ever wrapping
                        if (dcnt == last_cur) begin
                            state <= S_TAIL;
                        end
                    end
                end
                S_TAIL: begin
                    if (in_valid) begin
                        tail_bits[tslot +: 3] <= triplet;
                        tcnt                  <= tcnt + 2'd1;
                        if (tcnt == 2'd3) begin
                            state <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (in_valid) begin
                        err_overflow <= 1'b1;
                    end
                    if (blk_ack) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef SYS_CRC24B_EN
    logic [23:0] crc;

    function automatic logic [23:0] crc_step(input logic [23:0] c, input logic b);
        logic fb;
        fb = c[23] ^ b;
        return {c[22:0], 1'b0} ^ (fb ? 24'h800063 : 24'h000000);
    endfunction

    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            crc    <= '0;
            crc_ok <= 1'b0;
        end else if (in_valid) begin
            if (state == S_IDLE) begin
                crc    <= crc_step(24'h000000, d0);
                crc_ok <= 1'b0;
            end else if (state == S_DATA) begin
                crc <= crc_step(crc, d0);
            end else if (state == S_TAIL && tcnt == 2'd3) begin
                crc_ok <= (crc == 24'h000000);
            end
        end
    end
`else
    assign crc_ok = 1'b0;
`endif

endmodule
